fifo_burst_reader: RTL and testbench



---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_skid2.sv | 48 ++++
 rtl/fifo_burst_reader.sv | 144 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst-read path: controller state encoding,
// FIFO read latency and skid buffer depth.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // fifo_syn q is registered: data appears one cycle after rd
    localparam int RD_LAT     = 1;
    // entries in the output skid buffer
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry FIFO used as the output skid buffer of the burst reader.
// Push and pop may happen in the same cycle at any occupancy; clr empties it.
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;

    // storage, pointers and occupancy; reset/clear also zero the entries so
    // the head reads as 0 while empty after a reset
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = r_mem[r_rd_ptr];
    assign occ  = r_occ;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side controller for fifo_syn: drains a commanded number of bytes and
// presents them on a valid/ready stream. A credit count over skid occupancy
// and the in-flight read keeps the skid buffer from overflowing while still
// sustaining one byte per cycle.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             abort,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rd,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] rd_cnt
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_rd_cnt;
    logic [RD_LAT-1:0] r_rd_pipe;
    logic              r_done_zero;

    logic              w_inflight;
    logic [1:0]        w_occ;
    logic [WIDTH-1:0]  w_head;
    logic              w_pop;
    logic              w_credit_ok;
    logic [2:0]        w_used;
    logic [2:0]        w_room;
    logic              w_fifo_rd;
    logic              w_load;
    logic              w_zero_start;
    logic              w_flush_done;
    logic              w_skid_clr;

    assign w_inflight = r_rd_pipe[RD_LAT-1];
    assign m_valid    = (w_occ != 2'd0) && (r_state != ST_ABORT);
    assign w_pop      = m_valid && m_ready;

    // credit > 0  <=>  occ + inflight < depth + (byte leaving this cycle)
    assign w_used      = {1'b0, w_occ} + {2'b0, w_inflight};
    assign w_room      = 3'(SKID_DEPTH) + {2'b0, w_pop};
    assign w_credit_ok = (w_used < w_room);

    assign w_fifo_rd    = (r_state == ST_RUN) && !fifo_empty && (r_remaining != '0)
                          && w_credit_ok && !abort;
    assign w_load       = (r_state == ST_IDLE) && start && (burst_len != '0);
    assign w_zero_start = (r_state == ST_IDLE) && start && (burst_len == '0);
    assign w_skid_clr   = (r_state == ST_ABORT) && !w_inflight;

    // next-state logic; FLUSH completes on acceptance of the final byte
    always_comb begin
        w_state_nxt  = r_state;
        w_flush_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_ABORT;
                end else if (w_fifo_rd && (r_remaining == LEN_W'(1))) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    w_state_nxt = ST_ABORT;
                end else if (!w_inflight && (w_occ == 2'd1) && w_pop) begin
                    w_state_nxt  = ST_IDLE;
                    w_flush_done = 1'b1;
                end
            end
            ST_ABORT: begin
                if (!w_inflight) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // burst counters, in-flight read tracking and zero-length done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_rd_cnt    <= '0;
            r_rd_pipe   <= '0;
            r_done_zero <= 1'b0;
        end else begin
            r_rd_pipe   <= RD_LAT'({r_rd_pipe, w_fifo_rd});
            r_done_zero <= w_zero_start;
            if (w_load) begin
                r_remaining <= burst_len;
                r_rd_cnt    <= '0;
            end else if (w_fifo_rd) begin
                r_remaining <= r_remaining - LEN_W'(1);
                r_rd_cnt    <= r_rd_cnt + LEN_W'(1);
            end
        end
    end

    fifo_skid2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_skid_clr),
        .push      (w_inflight),
        .push_data (fifo_q),
        .pop       (w_pop),
        .head      (w_head),
        .occ       (w_occ)
    );

    assign fifo_rd = w_fifo_rd;
    assign m_data  = w_head;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done_zero || w_flush_done;
    assign rd_cnt  = r_rd_cnt;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed testbench for fifo_burst_reader with a small fifo_syn read-port model.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] burst_len;
    logic       abort;
    logic       fifo_empty;
    logic [7:0] fifo_q = 8'h00;
    logic       fifo_rd;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       done;
    logic [7:0] rd_cnt;

    int checks = 0;
    int errors = 0;

    // FIFO model: bench appends at wp, reads consume at rp
    logic [7:0] mem [64];
    int         wp = 0;
    int         rp = 0;
    logic [7:0] got [$];
    logic [7:0] pre [8];

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_q <= mem[rp & 63];
            rp     <= rp + 1;
        end
    end

    fifo_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rd    (fifo_rd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .rd_cnt     (rd_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fpush(input logic [7:0] b);
        mem[wp & 63] = b;
        wp = wp + 1;
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) fpush(pre[i]);
    endtask

    // rpat 0: always ready; 1: ready pattern 1,0,0,...
    task automatic run(input int budget, input int rpat, input bit use_credit, input bit want_done);
        int         acc;
        int         rds;
        bit         held;
        bit         seen;
        logic [7:0] hv;
        acc = 0; rds = 0; held = 0; seen = 0; hv = 8'h00;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            start   = 1'b0;
            m_ready = (rpat == 0) ? 1'b1 : ((c % 3) == 0);
            #1;
            chk("rd_while_empty", {31'b0, fifo_rd & fifo_empty}, 32'd0);
            if (held) begin
                chk("stall_valid", {31'b0, m_valid}, 32'd1);
                chk("stall_data", {24'b0, m_data}, {24'b0, hv});
            end
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                acc++;
            end
            if (fifo_rd) rds++;
            if (use_credit) chk("credit_limit", {31'b0, (rds - acc) <= 2}, 32'd1);
            held = m_valid && !m_ready;
            hv   = m_data;
            if (done) seen = 1'b1;
        end
        chk("done_seen", {31'b0, seen}, {31'b0, want_done});
    endtask

    initial begin
        pre[0] = 8'hab; pre[1] = 8'h12; pre[2] = 8'h34; pre[3] = 8'h56;
        pre[4] = 8'h78; pre[5] = 8'hcd; pre[6] = 8'hcc; pre[7] = 8'hdd;
        rst_n = 1'b0; start = 1'b0; burst_len = 8'd0; abort = 1'b0; m_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_fifo_rd", {31'b0, fifo_rd}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_m_data", {24'b0, m_data}, 32'd0);
        chk("rst_rd_cnt", {24'b0, rd_cnt}, 32'd0);

        // full-rate 8-byte burst
        @(negedge clk);
        rst_n = 1'b1;
        preload();
        @(negedge clk);
        start = 1'b1; burst_len = 8'd8; m_ready = 1'b1;
        #1;
        chk("t1_idle_busy", {31'b0, busy}, 32'd0);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("t1_fifo_rd", {31'b0, fifo_rd}, {31'b0, cyc <= 8});
            chk("t1_m_valid", {31'b0, m_valid}, {31'b0, cyc >= 3});
            if (cyc >= 3) chk("t1_m_data", {24'b0, m_data}, {24'b0, pre[cyc-3]});
            chk("t1_done", {31'b0, done}, {31'b0, cyc == 10});
        end
        @(negedge clk);
        #1;
        chk("t1_busy_end", {31'b0, busy}, 32'd0);
        chk("t1_rd_cnt", {24'b0, rd_cnt}, 32'd8);
        chk("t1_fifo_empty", {31'b0, fifo_empty}, 32'd1);

        // sink stalls: ready 1,0,0 pattern
        got.delete();
        preload();
        @(negedge clk);
        start = 1'b1; burst_len = 8'd8;
        run(100, 1, 1'b1, 1'b1);
        chk("t2_count", got.size(), 32'd8);
        for (int i = 0; i < 8; i++) chk("t2_byte", {24'b0, got[i]}, {24'b0, pre[i]});
        @(negedge clk);
        #1;
        chk("t2_rd_cnt", {24'b0, rd_cnt}, 32'd8);
        chk("t2_busy_end", {31'b0, busy}, 32'd0);

        // FIFO runs dry mid-burst, then refills
        got.delete();
        m_ready = 1'b1;
        fpush(8'hab); fpush(8'h12);
        @(negedge clk);
        start = 1'b1; burst_len = 8'd4;
        run(10, 0, 1'b0, 1'b0);
        chk("t3_partial_count", got.size(), 32'd2);
        chk("t3_busy_stall", {31'b0, busy}, 32'd1);
        chk("t3_rd_cnt_stall", {24'b0, rd_cnt}, 32'd2);
        fpush(8'h55); fpush(8'hee);
        run(20, 0, 1'b0, 1'b1);
        chk("t3_count", got.size(), 32'd4);
        chk("t3_b0", {24'b0, got[0]}, 32'hab);
        chk("t3_b1", {24'b0, got[1]}, 32'h12);
        chk("t3_b2", {24'b0, got[2]}, 32'h55);
        chk("t3_b3", {24'b0, got[3]}, 32'hee);

        // abort one cycle after the 3rd read
        preload();
        @(negedge clk);
        start = 1'b1; burst_len = 8'd8; m_ready = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("t4_fifo_rd", {31'b0, fifo_rd}, 32'd1);
        end
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("t4_rd_forced_off", {31'b0, fifo_rd}, 32'd0);
        chk("t4_done_a", {31'b0, done}, 32'd0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("t4_rd_abort", {31'b0, fifo_rd}, 32'd0);
        chk("t4_done_b", {31'b0, done}, 32'd0);
        @(negedge clk);
        #1;
        chk("t4_busy_drop", {31'b0, busy}, 32'd0);
        chk("t4_done_c", {31'b0, done}, 32'd0);
        chk("t4_rd_cnt", {24'b0, rd_cnt}, 32'd3);
        chk("t4_fifo_level", wp - rp, 32'd5);

        // zero-length burst
        @(negedge clk);
        start = 1'b1; burst_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("t5_done", {31'b0, done}, 32'd1);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_fifo_rd", {31'b0, fifo_rd}, 32'd0);
        @(negedge clk);
        #1;
        chk("t5_done_once", {31'b0, done}, 32'd0);

        // reset mid-burst with the skid buffer full (FIFO holds 56,78,cd,cc,dd)
        @(negedge clk);
        start = 1'b1; burst_len = 8'd8; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("t6_rd1", {31'b0, fifo_rd}, 32'd1);
        @(negedge clk);
        #1;
        chk("t6_rd2", {31'b0, fifo_rd}, 32'd1);
        @(negedge clk);
        #1;
        chk("t6_no_credit", {31'b0, fifo_rd}, 32'd0);
        chk("t6_head", {24'b0, m_data}, 32'h56);
        @(negedge clk);
        #1;
        chk("t6_full_rd", {31'b0, fifo_rd}, 32'd0);
        chk("t6_full_valid", {31'b0, m_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_rst_valid", {31'b0, m_valid}, 32'd0);
        chk("t6_rst_rd", {31'b0, fifo_rd}, 32'd0);
        chk("t6_rst_rd_cnt", {24'b0, rd_cnt}, 32'd0);
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_rst_data", {24'b0, m_data}, 32'd0);
        got.delete();
        @(negedge clk);
        start = 1'b1; burst_len = 8'd2;
        run(20, 0, 1'b0, 1'b1);
        chk("t6_count", got.size(), 32'd2);
        chk("t6_b0", {24'b0, got[0]}, 32'hcd);
        chk("t6_b1", {24'b0, got[1]}, 32'hcc);
        @(negedge clk);
        #1;
        chk("t6_rd_cnt", {24'b0, rd_cnt}, 32'd2);
        chk("t6_fifo_level", wp - rp, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
